rename_tag_allocator: RTL and testbench

- Owns the pool of rename tags and hands them to the two renamer slots each cycle.
- Implemented as a circular free list: tags are popped at rename and pushed back on commit.
- Reports rename capacity (0/1/2) to the instruction processor query path so dispatch stalls cleanly.
- Restores the full pool on a pipeline flush (branch mispredict/exception).

---
 rtl/rename_tag_allocator.sv | 97 +++++++++
 tb/tb_rename_tag_allocator.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/rename_tag_allocator.sv
// Rename tag free list: a circular buffer of tags. Up to two tags are handed
// out each cycle (tags popped at head) and up to two are returned from commit
// (tags pushed at tail). A flush reloads the identity pool.
module rename_tag_allocator #(
    parameter int TAG_COUNT = 32,
    parameter int TAG_WIDTH = 5
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic [1:0]                i_alloc_req,
    input  logic                      i_halt,
    output logic [1:0]                o_alloc_grant,
    output logic [1:0][TAG_WIDTH-1:0] o_alloc_tag,
    input  logic [1:0]                i_free_valid,
    input  logic [1:0][TAG_WIDTH-1:0] i_free_tag,
    input  logic                      i_flush,
    output logic [1:0]                o_query_ren_capacity,
    output logic                      o_ren_empty,
    output logic [TAG_WIDTH:0]        o_count,
    output logic                      o_overflow
);

    typedef logic [TAG_WIDTH:0]   cnt_t;
    typedef logic [TAG_WIDTH-1:0] tag_t;

    localparam cnt_t FULL = cnt_t'(TAG_COUNT);

    tag_t tag_mem [TAG_COUNT];
    tag_t head, tail;
    cnt_t count;
    logic overflow;

    cnt_t n_req, n_grant, n_write, room;
    logic grant_ok, acc0, acc1, drop;
    tag_t head_p1, wr_idx1;

    // Grant decision, tag selection and free acceptance, all from pre-edge state
    always_comb begin
        n_req    = cnt_t'(i_alloc_req[0]) + cnt_t'(i_alloc_req[1]);
        grant_ok = !i_halt && !i_flush && (count >= n_req);
        o_alloc_grant = grant_ok ? i_alloc_req : 2'b00;
        n_grant  = grant_ok ? n_req : '0;

        // Lowest requested slot takes head; slot 1 takes head+1 only when slot 0 also asks
        head_p1        = head + tag_t'(1);
        o_alloc_tag[0] = tag_mem[head];
        o_alloc_tag[1] = i_alloc_req[0] ? tag_mem[head_p1] : tag_mem[head];

        // Free slots left after this cycle's pops; port 1 is the first to be dropped
        room    = FULL - (count - n_grant);
        acc0    = !i_flush && i_free_valid[0] && (room >= cnt_t'(1));
        acc1    = !i_flush && i_free_valid[1] && (room >= (acc0 ? cnt_t'(2) : cnt_t'(1)));
        drop    = !i_flush && ((i_free_valid[0] && !acc0) || (i_free_valid[1] && !acc1));
        n_write = cnt_t'(acc0) + cnt_t'(acc1);
        wr_idx1 = acc0 ? tail + tag_t'(1) : tail;
    end

    // Tag storage: identity on reset/flush, otherwise accepted frees land at tail
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            for (int i = 0; i < TAG_COUNT; i++) tag_mem[i] <= tag_t'(i);
        end else if (i_flush) begin
            for (int i = 0; i < TAG_COUNT; i++) tag_mem[i] <= tag_t'(i);
        end else begin
            if (acc0) tag_mem[tail]    <= i_free_tag[0];
            if (acc1) tag_mem[wr_idx1] <= i_free_tag[1];
        end
    end

    // Pointers, occupancy and the sticky overflow flag (which survives flush)
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            head     <= '0;
            tail     <= '0;
            count    <= FULL;
            overflow <= 1'b0;
        end else if (i_flush) begin
            head  <= '0;
            tail  <= '0;
            count <= FULL;
        end else begin
            head  <= head + tag_t'(n_grant);
            tail  <= tail + tag_t'(n_write);
            count <= count - n_grant + n_write;
            if (drop) overflow <= 1'b1;
        end
    end

    // Capacity reporting comes only from registered count
    always_comb begin
        o_query_ren_capacity = (count >= cnt_t'(2)) ? 2'd2 : count[1:0];
        o_ren_empty          = (count == '0);
        o_count              = count;
        o_overflow           = overflow;
    end

endmodule

// File: tb/tb_rename_tag_allocator.sv
// Directed bench for rename_tag_allocator: each task drives one scenario and
// checks hand-computed expectations inline.
module tb_rename_tag_allocator;

    localparam int TC = 32;
    localparam int TW = 5;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [1:0]        alloc_req;
    logic              halt;
    logic [1:0]        alloc_grant;
    logic [1:0][TW-1:0] alloc_tag;
    logic [1:0]        free_valid;
    logic [1:0][TW-1:0] free_tag;
    logic              flush;
    logic [1:0]        cap;
    logic              empty;
    logic [TW:0]       count;
    logic              overflow;

    int vectors = 0;
    int miscompares = 0;

    rename_tag_allocator #(.TAG_COUNT(TC), .TAG_WIDTH(TW)) dut (
        .i_clock(clk), .i_reset(rst_n), .i_alloc_req(alloc_req), .i_halt(halt),
        .o_alloc_grant(alloc_grant), .o_alloc_tag(alloc_tag),
        .i_free_valid(free_valid), .i_free_tag(free_tag), .i_flush(flush),
        .o_query_ren_capacity(cap), .o_ren_empty(empty), .o_count(count),
        .o_overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        alloc_req = 2'b00; halt = 1'b0; free_valid = 2'b00; flush = 1'b0;
        free_tag = '0;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++; if (alloc_grant !== 2'b00) begin miscompares++; $display("FAIL reset_grant got=%b exp=00", alloc_grant); end
        vectors++; if (cap !== 2'd2) begin miscompares++; $display("FAIL reset_cap got=%0d exp=2", cap); end
        vectors++; if (empty !== 1'b0) begin miscompares++; $display("FAIL reset_empty got=%b exp=0", empty); end
        vectors++; if (count !== 6'd32) begin miscompares++; $display("FAIL reset_count got=%0d exp=32", count); end
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    endtask

    task automatic test_dual_alloc();
        do_reset();
        alloc_req = 2'b11; #1;
        vectors++; if (alloc_grant !== 2'b11) begin miscompares++; $display("FAIL dual_grant0 got=%b exp=11", alloc_grant); end
        vectors++; if (alloc_tag[0] !== 5'd0 || alloc_tag[1] !== 5'd1) begin miscompares++; $display("FAIL dual_tags0 got=%0d,%0d exp=0,1", alloc_tag[0], alloc_tag[1]); end
        vectors++; if (cap !== 2'd2 || count !== 6'd32) begin miscompares++; $display("FAIL dual_nocomb got=%0d/%0d exp=2/32", cap, count); end
        tick();
        vectors++; if (count !== 6'd30) begin miscompares++; $display("FAIL dual_count1 got=%0d exp=30", count); end
        vectors++; if (alloc_tag[0] !== 5'd2 || alloc_tag[1] !== 5'd3) begin miscompares++; $display("FAIL dual_tags1 got=%0d,%0d exp=2,3", alloc_tag[0], alloc_tag[1]); end
        tick();
        alloc_req = 2'b00;
        vectors++; if (count !== 6'd28) begin miscompares++; $display("FAIL dual_count2 got=%0d exp=28", count); end
    endtask

    task automatic test_slot1_only();
        do_reset();
        alloc_req = 2'b10; #1;
        vectors++; if (alloc_grant !== 2'b10) begin miscompares++; $display("FAIL slot1_grant got=%b exp=10", alloc_grant); end
        vectors++; if (alloc_tag[1] !== 5'd0) begin miscompares++; $display("FAIL slot1_tag got=%0d exp=0", alloc_tag[1]); end
        tick();
        alloc_req = 2'b00;
        vectors++; if (count !== 6'd31) begin miscompares++; $display("FAIL slot1_count got=%0d exp=31", count); end
    endtask

    // Leaves the list empty with head=tail=0
    task automatic test_drain();
        do_reset();
        alloc_req = 2'b11;
        for (int i = 0; i < 15; i++) tick();
        alloc_req = 2'b01;
        tick();
        alloc_req = 2'b00;
        vectors++; if (count !== 6'd1 || cap !== 2'd1) begin miscompares++; $display("FAIL drain_count got=%0d/%0d exp=1/1", count, cap); end
        alloc_req = 2'b11; #1;
        vectors++; if (alloc_grant !== 2'b00) begin miscompares++; $display("FAIL drain_nogrant got=%b exp=00", alloc_grant); end
        alloc_req = 2'b01; #1;
        vectors++; if (alloc_grant !== 2'b01 || alloc_tag[0] !== 5'd31) begin miscompares++; $display("FAIL drain_last got=%b/%0d exp=01/31", alloc_grant, alloc_tag[0]); end
        tick();
        alloc_req = 2'b00; #1;
        vectors++; if (empty !== 1'b1 || cap !== 2'd0 || count !== 6'd0) begin miscompares++; $display("FAIL drain_empty got=%b/%0d/%0d exp=1/0/0", empty, cap, count); end
    endtask

    task automatic test_free_at_empty();
        free_valid = 2'b01; free_tag[0] = 5'd7; alloc_req = 2'b01; #1;
        vectors++; if (alloc_grant !== 2'b00) begin miscompares++; $display("FAIL empty_samecycle got=%b exp=00", alloc_grant); end
        tick();
        free_valid = 2'b00; #1;
        vectors++; if (count !== 6'd1) begin miscompares++; $display("FAIL empty_count1 got=%0d exp=1", count); end
        vectors++; if (alloc_grant !== 2'b01 || alloc_tag[0] !== 5'd7) begin miscompares++; $display("FAIL empty_tag7 got=%b/%0d exp=01/7", alloc_grant, alloc_tag[0]); end
        tick();
        alloc_req = 2'b00;
        vectors++; if (count !== 6'd0) begin miscompares++; $display("FAIL empty_count0 got=%0d exp=0", count); end
    endtask

    task automatic test_wrap();
        int bad;
        do_reset();
        bad = 0;
        alloc_req = 2'b11;
        for (int k = 0; k < 16; k++) begin
            #1;
            if (alloc_grant !== 2'b11 || alloc_tag[0] !== TW'(2*k) || alloc_tag[1] !== TW'(2*k+1)) bad++;
            tick();
        end
        alloc_req = 2'b00;
        vectors++; if (bad != 0 || count !== 6'd0) begin miscompares++; $display("FAIL wrap_first32 got=%0d bad/count=%0d exp=0/0", bad, count); end
        for (int k = 0; k < 16; k++) begin
            free_valid = 2'b11; free_tag[0] = TW'(2*k); free_tag[1] = TW'(2*k+1);
            tick();
        end
        free_valid = 2'b00;
        vectors++; if (count !== 6'd32 || overflow !== 1'b0) begin miscompares++; $display("FAIL wrap_refill got=%0d/%b exp=32/0", count, overflow); end
        // Return 0,1 during the first pop cycle so a 17th pair is available
        bad = 0;
        alloc_req = 2'b11;
        for (int k = 0; k < 16; k++) begin
            free_valid = (k == 0) ? 2'b11 : 2'b00; free_tag[0] = 5'd0; free_tag[1] = 5'd1;
            #1;
            if (alloc_grant !== 2'b11 || alloc_tag[0] !== TW'(2*k) || alloc_tag[1] !== TW'(2*k+1)) bad++;
            tick();
        end
        free_valid = 2'b00; #1;
        vectors++; if (bad != 0 || count !== 6'd2) begin miscompares++; $display("FAIL wrap_second32 got=%0d bad/count=%0d exp=0/2", bad, count); end
        vectors++; if (alloc_grant !== 2'b11 || alloc_tag[0] !== 5'd0 || alloc_tag[1] !== 5'd1) begin miscompares++; $display("FAIL wrap_around got=%b/%0d,%0d exp=11/0,1", alloc_grant, alloc_tag[0], alloc_tag[1]); end
        tick();
        alloc_req = 2'b00;
        vectors++; if (count !== 6'd0) begin miscompares++; $display("FAIL wrap_count got=%0d exp=0", count); end
    endtask

    task automatic test_flush();
        do_reset();
        alloc_req = 2'b11;
        for (int i = 0; i < 5; i++) tick();
        alloc_req = 2'b00;
        // Overwrite entries 0,1 so only an identity reload yields 0,1 again
        free_valid = 2'b11; free_tag[0] = 5'd9; free_tag[1] = 5'd8;
        tick();
        free_valid = 2'b00;
        vectors++; if (count !== 6'd24) begin miscompares++; $display("FAIL flush_pre got=%0d exp=24", count); end
        flush = 1'b1; alloc_req = 2'b11; free_valid = 2'b11; free_tag[0] = 5'd3; free_tag[1] = 5'd4; #1;
        vectors++; if (alloc_grant !== 2'b00) begin miscompares++; $display("FAIL flush_grant got=%b exp=00", alloc_grant); end
        tick();
        flush = 1'b0; free_valid = 2'b00; #1;
        vectors++; if (count !== 6'd32 || overflow !== 1'b0) begin miscompares++; $display("FAIL flush_count got=%0d/%b exp=32/0", count, overflow); end
        vectors++; if (alloc_grant !== 2'b11 || alloc_tag[0] !== 5'd0 || alloc_tag[1] !== 5'd1) begin miscompares++; $display("FAIL flush_tags got=%b/%0d,%0d exp=11/0,1", alloc_grant, alloc_tag[0], alloc_tag[1]); end
        tick();
        alloc_req = 2'b00;
        vectors++; if (count !== 6'd30) begin miscompares++; $display("FAIL flush_after got=%0d exp=30", count); end
    endtask

    task automatic test_halt();
        halt = 1'b1; alloc_req = 2'b01; #1;
        vectors++; if (alloc_grant !== 2'b00) begin miscompares++; $display("FAIL halt_grant got=%b exp=00", alloc_grant); end
        tick();
        halt = 1'b0; alloc_req = 2'b00;
        vectors++; if (count !== 6'd30) begin miscompares++; $display("FAIL halt_count got=%0d exp=30", count); end
    endtask

    task automatic test_overflow();
        flush = 1'b1; tick(); flush = 1'b0;
        free_valid = 2'b11; free_tag[0] = 5'd5; free_tag[1] = 5'd6;
        tick();
        free_valid = 2'b00;
        vectors++; if (overflow !== 1'b1 || count !== 6'd32) begin miscompares++; $display("FAIL ovf_full got=%b/%0d exp=1/32", overflow, count); end
        flush = 1'b1; tick(); flush = 1'b0;
        vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_flush_keep got=%b exp=1", overflow); end
        do_reset();
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL ovf_reset got=%b exp=0", overflow); end
        // One slot free: port 0 accepted, port 1 dropped
        alloc_req = 2'b01; tick(); alloc_req = 2'b00;
        free_valid = 2'b11; free_tag[0] = 5'd20; free_tag[1] = 5'd21;
        tick();
        free_valid = 2'b00;
        vectors++; if (overflow !== 1'b1 || count !== 6'd32) begin miscompares++; $display("FAIL ovf_partial got=%b/%0d exp=1/32", overflow, count); end
        // The accepted tag 20 went to slot 0 and is popped after 31 others
        alloc_req = 2'b11;
        for (int i = 0; i < 15; i++) tick();
        alloc_req = 2'b01; #1;
        vectors++; if (alloc_tag[0] !== 5'd31) begin miscompares++; $display("FAIL ovf_order31 got=%0d exp=31", alloc_tag[0]); end
        tick(); #1;
        vectors++; if (alloc_grant !== 2'b01 || alloc_tag[0] !== 5'd20) begin miscompares++; $display("FAIL ovf_tag20 got=%b/%0d exp=01/20", alloc_grant, alloc_tag[0]); end
        alloc_req = 2'b00;
    endtask

    initial begin
        rst_n = 1'b1; alloc_req = 2'b00; halt = 1'b0; free_valid = 2'b00; flush = 1'b0; free_tag = '0;
        tick();
        test_reset();
        test_dual_alloc();
        test_slot1_only();
        test_drain();
        test_free_at_empty();
        test_wrap();
        test_flush();
        test_halt();
        test_overflow();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
